// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests the word at PC from instruction memory, holds it for
// the control unit until acknowledged, then advances PC. Optional macro: MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int                    instr_length = 32,
    parameter int                    addr_width   = 32,
    parameter logic [addr_width-1:0] RESET_PC     = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req,
    output logic [addr_width-1:0]   imem_addr,
    input  logic                    imem_ready,
    input  logic                    imem_rvalid,
    input  logic [instr_length-1:0] imem_rdata,
    output logic [instr_length-1:0] instr,
    output logic                    instr_valid,
    input  logic                    instr_ack,
    input  logic                    PCsrc,
    input  logic [addr_width-1:0]   ImmOp,
    output logic [addr_width-1:0]   PC,
    output logic                    misalign,
    output logic [2:0]              dbg_state_o
);

    // Handshakes: a request is accepted on a rising edge where imem_req && imem_ready;
    // data is taken on an edge where imem_rvalid is high in REQ (same-cycle) or WAIT;
    // instr is offered while instr_valid and consumed on an edge where instr_ack is high.
`ifdef MISALIGN_TRAP_EN
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD, ST_HALT} state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} state_e;
`endif

    localparam logic [addr_width-1:0] PC_STEP = addr_width'(4);

    state_e                  state_q, state_d;
    logic [addr_width-1:0]   pc_q, pc_d;
    logic [instr_length-1:0] instr_q, instr_d;
    logic [addr_width-1:0]   pc_next;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Wraps naturally modulo 2^addr_width.
    assign pc_next = PCsrc ? (pc_q + ImmOp) : (pc_q + PC_STEP);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ready) begin
                    if (imem_rvalid) begin
                        instr_d = imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ack) begin
`ifdef MISALIGN_TRAP_EN
                    // A misaligned target freezes the PC at the offending instruction.
                    if (pc_next[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d    = pc_next;
                        state_d = ST_REQ;
                    end
`else
                    pc_d    = pc_next;
                    state_d = ST_REQ;
`endif
                end
            end
`ifdef MISALIGN_TRAP_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_HOLD);
    assign PC          = pc_q;
    assign dbg_state_o = state_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory driver issues fetches and pushes the expected
// {addr, instr} pair; a monitor pops it whenever a new instruction becomes valid.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic        PCsrc = 1'b0;
    logic [31:0] ImmOp = '0;
    logic [31:0] PC;
    logic        misalign;
    logic [2:0]  dbg_state;

    localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT = 3'd2;
    localparam int TIMEOUT = 50;

    logic [63:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic prev_valid = 1'b0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
        .PCsrc(PCsrc), .ImmOp(ImmOp), .PC(PC), .misalign(misalign),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected: got instr %h at PC %h expected none", instr, PC);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("mon_instr", 64'(instr), 64'(e[31:0]));
                check("mon_pc", 64'(PC), 64'(e[63:32]));
            end
        end
        prev_valid = instr_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_req(output bit ok);
        int t = 0;
        @(negedge clk);
        while (!imem_req && t < TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        ok = imem_req;
        if (!ok) check("req_timeout", 64'(imem_req), 64'd1);
    endtask

    // Serves one fetch: ready after rdly stall cycles, rvalid vdly cycles after acceptance.
    // Acks issued during the stall must be ignored by the DUT.
    task automatic serve(input logic [31:0] addr, input logic [31:0] data,
                         input int rdly, input int vdly);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        check("req_addr", 64'(imem_addr), 64'(addr));
        exp_q.push_back({addr, data});
        for (int i = 0; i < rdly; i++) begin
            imem_ready = 1'b0;
            instr_ack  = 1'b1;
            PCsrc      = 1'b1;
            ImmOp      = 32'h100;
            @(negedge clk);
            check("req_held", 64'(imem_req), 64'd1);
        end
        instr_ack = 1'b0;
        PCsrc     = 1'b0;
        ImmOp     = '0;
        imem_ready = 1'b1;
        imem_rvalid = (vdly == 0);
        imem_rdata  = (vdly == 0) ? data : $urandom;
        @(negedge clk);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (vdly > 0) begin
            for (int i = 0; i < vdly - 1; i++) begin
                check("wait_no_req", 64'(imem_req), 64'd0);
                check("wait_state", 64'(dbg_state), 64'(S_WAIT));
                @(negedge clk);
            end
            imem_rvalid = 1'b1;
            imem_rdata  = data;
            @(negedge clk);
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        check("valid_after_data", 64'(instr_valid), 64'd1);
    endtask

    // Holds the instruction for `hold` cycles (with stray rvalid pulses), then acks.
    task automatic ack(input bit src, input logic [31:0] imm, input int hold);
        int t = 0;
        logic [31:0] held;
        while (!instr_valid && t < TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        if (!instr_valid) begin
            check("valid_timeout", 64'(instr_valid), 64'd1);
            return;
        end
        held = instr;
        for (int i = 0; i < hold; i++) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
            @(negedge clk);
            check("hold_stable", 64'(instr), 64'(held));
            check("hold_valid", 64'(instr_valid), 64'd1);
        end
        imem_rvalid = 1'b0;
        instr_ack = 1'b1;
        PCsrc     = src;
        ImmOp     = imm;
        @(negedge clk);
        instr_ack = 1'b0;
        PCsrc     = 1'b0;
        ImmOp     = '0;
`ifndef MISALIGN_TRAP_EN
        check("valid_drop", 64'(instr_valid), 64'd0);
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        repeat (2) @(negedge clk);
        check("rst_pc", 64'(PC), 64'h0);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'h0);
        check("rst_misalign", 64'(misalign), 64'd0);
        rst_n = 1'b1;
        check("idle_state", 64'(dbg_state), 64'(S_IDLE));

        serve(32'h0, 32'h00500093, 0, 0);
        ack(1'b0, '0, 0);
        serve(32'h4, 32'h00000013, 3, 2);
        ack(1'b0, '0, 3);
        serve(32'h8, 32'h00a00113, 0, 1);
        ack(1'b0, '0, 1);
        serve(32'hC, 32'h002081b3, 1, 0);
        ack(1'b0, '0, 0);
        serve(32'h10, 32'hfe000ce3, 0, 0);
        ack(1'b1, 32'hFFFFFFF8, 0);
        check("branch_back_pc", 64'(PC), 64'h8);
        serve(32'h8, 32'h11111111, 0, 0);
        ack(1'b1, 32'hFFFFFFF4, 0);
        check("branch_wrap_pc", 64'(PC), 64'hFFFFFFFC);
        serve(32'hFFFFFFFC, 32'h22222222, 2, 0);
        ack(1'b0, '0, 0);
        check("seq_wrap_pc", 64'(PC), 64'h0);
        serve(32'h0, 32'h33333333, 0, 0);
        ack(1'b0, '0, 0);

        // Reset while waiting on data; a late rvalid in IDLE must be dropped.
        wait_req(ok);
        check("pre_rst_addr", 64'(imem_addr), 64'h4);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        check("pre_rst_wait", 64'(dbg_state), 64'(S_WAIT));
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", 64'(PC), 64'h0);
        check("async_rst_state", 64'(dbg_state), 64'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("post_rst_state", 64'(dbg_state), 64'(S_REQ));
        check("post_rst_valid", 64'(instr_valid), 64'd0);
        check("post_rst_instr", 64'(instr), 64'h0);
        check("post_rst_addr", 64'(imem_addr), 64'h0);

        serve(32'h0, 32'h44444444, 0, 0);
        ack(1'b0, '0, 0);
        serve(32'h4, 32'h55555555, 0, 0);
        ack(1'b1, 32'h2, 0);
`ifdef MISALIGN_TRAP_EN
        check("trap_pc", 64'(PC), 64'h4);
        check("trap_misalign", 64'(misalign), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("trap_no_req", 64'(imem_req), 64'd0);
        end
`else
        check("odd_pc", 64'(PC), 64'h6);
        check("odd_misalign", 64'(misalign), 64'd0);
        serve(32'h6, 32'h66666666, 0, 0);
        ack(1'b0, '0, 0);
`endif

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter instr_length SHALL default to 32; it is the instruction word width.
REQ-002 Parameter addr_width SHALL default to 32; it is the PC and instruction-memory address width.
REQ-003 Parameter RESET_PC SHALL default to 0; it is the PC value loaded on reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 imem_req  output  1  SHALL signal a fetch request to instruction memory.
REQ-007 imem_addr  output  addr_width  SHALL be the fetch address, equal to PC.
REQ-008 imem_ready  input  1  SHALL indicate that memory accepts the request this cycle.
REQ-009 imem_rvalid  input  1  SHALL qualify imem_rdata.
REQ-010 imem_rdata  input  instr_length  SHALL be the returned instruction word.
REQ-011 instr  output  instr_length  SHALL be the held instruction presented to the control unit.
REQ-012 instr_valid  output  1  SHALL mark instr as valid.
REQ-013 instr_ack  input  1  SHALL indicate downstream has consumed instr; PCsrc and ImmOp are sampled in the same cycle.
REQ-014 PCsrc  input  1  SHALL select the branch target (1) or sequential PC (0).
REQ-015 ImmOp  input  addr_width  SHALL be the sign-extended branch offset.
REQ-016 PC  output  addr_width  SHALL be the current program counter.
REQ-017 misalign  output  1  SHALL flag a misaligned next-PC (see Configuration).

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, REQ, WAIT and HOLD, plus HALT when MISALIGN_TRAP_EN is defined.
REQ-019 IDLE SHALL last one cycle after reset release, then go to REQ.
REQ-020 In REQ: imem_req=1 and imem_addr=PC; the FSM SHALL remain in REQ until imem_ready=1.
REQ-021 REQ with imem_ready=1 and imem_rvalid=0 SHALL go to WAIT.
REQ-022 REQ with imem_ready=1 and imem_rvalid=1 SHALL capture imem_rdata into instr and go directly to HOLD.
REQ-023 In WAIT: imem_req=0; imem_rvalid=1 SHALL capture imem_rdata into instr and go to HOLD.
REQ-024 In HOLD: instr_valid=1; instr SHALL remain stable until instr_ack=1.
REQ-025 On instr_ack=1 in HOLD: next = PCsrc ? PC+ImmOp : PC+4, PC SHALL load next, instr_valid SHALL drop next cycle, and the FSM SHALL go to REQ.
REQ-026 PC arithmetic SHALL be modulo 2^addr_width; 0xFFFFFFFC+4 SHALL wrap to 0x00000000.
REQ-027 imem_rvalid SHALL be ignored in IDLE, HOLD and HALT.
REQ-028 instr_ack SHALL be ignored outside HOLD.
REQ-029 Minimum fetch latency (REQ entry to instr_valid) SHALL be 1 cycle with same-cycle ready and rvalid.

Reset
REQ-030 rst_n=0 SHALL asynchronously set PC=RESET_PC, state=IDLE, instr=0, instr_valid=0, imem_req=0, misalign=0.
REQ-031 Reset mid-fetch SHALL abandon the outstanding request; a late imem_rvalid during IDLE SHALL be dropped.

Configuration
REQ-032 With MISALIGN_TRAP_EN defined: if next[1:0]!=0 on an acknowledged transfer, PC SHALL be held, misalign SHALL be set sticky, and the FSM SHALL enter HALT (no requests) until reset.
REQ-033 Without MISALIGN_TRAP_EN: next SHALL be loaded unmodified, misalign SHALL be tied 0, and HALT SHALL NOT exist.

Verification
REQ-034 Reset, then imem_ready=1 and imem_rvalid=1 returning 0x00500093 -> imem_addr=0x0, instr=0x00500093 with instr_valid=1 one cycle after REQ.
REQ-035 Ack with PCsrc=0 at PC=0x8 -> next request has imem_addr=0xC.
REQ-036 Ack with PCsrc=1, ImmOp=0xFFFFFFF8 at PC=0x10 -> PC=0x8.
REQ-037 imem_ready delayed 3 cycles and rvalid delayed 2 more -> imem_req held for 3 cycles; instr stable while instr_ack=0.
REQ-038 MISALIGN_TRAP_EN defined, ack with PCsrc=1, ImmOp=0x2 at PC=0x4 -> PC stays 0x4, misalign=1, imem_req stays 0.
REQ-039 rst_n asserted in WAIT, then rvalid pulsed during IDLE -> instr_valid=0, and the first request after IDLE is at RESET_PC.
